bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 The block SHALL have parameter BIN_W, default 8, giving the binary input width (legal 4..32).
REQ-002 The block SHALL have parameter DIGITS, default 3, giving the number of BCD output digits (legal 1..10).
REQ-003 Port clk  input  1  the single clock; all state SHALL change on its rising edge only.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port start  input  1  request a conversion of bin.
REQ-006 Port bin  input  BIN_W  binary operand, sampled only on the edge that accepts start.
REQ-007 Port busy  output  1  high while a conversion is in progress.
REQ-008 Port done  output  1  single-cycle pulse marking valid results.
REQ-009 Port bcd  output  4*DIGITS  packed BCD result, digit 0 in bits [3:0].
REQ-010 Port ovf  output  1  high when the result did not fit in DIGITS digits.

Function
REQ-011 The FSM SHALL have the states IDLE, SHIFT and DONE.
REQ-012 In IDLE or DONE, start=1 at an edge SHALL capture bin, clear the internal BCD scratch, load the iteration counter with BIN_W and enter SHIFT.
REQ-013 In IDLE or DONE, start=0 SHALL send the FSM to IDLE (or keep it there).
REQ-014 On each edge in SHIFT, every scratch digit >=5 SHALL have 3 added, and then {scratch, operand} SHALL shift left by one bit (double dabble).
REQ-015 If a 1 is shifted out of the top scratch digit, a sticky overflow bit SHALL be set for that conversion.
REQ-016 After exactly BIN_W SHIFT edges, the FSM SHALL enter DONE, register the scratch into bcd and the overflow bit into ovf, and assert done for exactly that one cycle.
REQ-017 Latency SHALL be BIN_W edges from the accepting edge to done high, with the next start accepted in the DONE cycle for back-to-back operation.
REQ-018 busy SHALL equal (state==SHIFT).
REQ-019 start while busy SHALL be ignored, with no effect on the conversion or operand.
REQ-020 bcd and ovf SHALL hold their last values until the next DONE and SHALL NOT change during SHIFT.
REQ-021 When ovf=1, bcd SHALL hold the low DIGITS digits of the true decimal value.
REQ-022 Every digit of bcd SHALL always be in the range 0..9.

Reset
REQ-023 rst=1 at an edge SHALL force state IDLE, busy=0, done=0, bcd=0, ovf=0 and clear the counter and scratch; this SHALL take priority over start.
REQ-024 rst during SHIFT SHALL abort the conversion with no done pulse.

Configuration
REQ-025 With macro BIN2BCD_SIGNED_EN defined, bin SHALL be treated as two's complement.
REQ-026 With BIN2BCD_SIGNED_EN, the magnitude SHALL be captured at accept and the output port sign (output, 1 bit) SHALL be registered at DONE and reset to 0.
REQ-027 With BIN2BCD_SIGNED_EN, -2^(BIN_W-1) SHALL convert to magnitude 2^(BIN_W-1).
REQ-028 Without BIN2BCD_SIGNED_EN, bin SHALL be unsigned, the sign port SHALL be absent, and latency SHALL be identical.

Verification
REQ-029 Defaults, bin=255, start pulse -> busy for 8 cycles, done pulse 8 edges after accept, bcd=12'h255, ovf=0.
REQ-030 Defaults, bin=0, then bin=100 back-to-back with start held in the DONE cycle -> bcd=12'h000 then 12'h100, done pulses 9 cycles apart.
REQ-031 DIGITS=2, bin=255 -> bcd=8'h55, ovf=1; a following bin=99 -> bcd=8'h99, ovf=0.
REQ-032 bin=42 accepted, start=1 with bin=7 pulsed 3 cycles later during busy -> result 12'h042, no extra done.
REQ-033 rst asserted 4 cycles into a conversion -> next cycle busy=0, done=0, bcd=0, and no done pulse follows.
REQ-034 BIN2BCD_SIGNED_EN, BIN_W=8: bin=8'h80 -> sign=1, bcd=12'h128; bin=8'hFF -> sign=1, bcd=12'h001; BIN_W=16: bin=16'd65535 with DIGITS=5 unsigned build -> bcd=20'h65535.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to packed BCD converter; BIN_W shift cycles per result.
// Ports: clk, rst (sync, active-high), start, bin -> busy, done, bcd, ovf [, sign].
// Optional macro BIN2BCD_SIGNED_EN treats bin as two's complement and adds the sign output.
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                ovf
`ifdef BIN2BCD_SIGNED_EN
    ,
    output logic                sign
`endif
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            w_accept;
    logic            w_last;
    logic [CW-1:0]   r_cnt;
    logic [BIN_W-1:0] r_op;
    logic [BIN_W-1:0] w_mag;
    logic [SW-1:0]   r_scr;
    logic [SW-1:0]   w_adj;
    logic [SW-1:0]   w_scr_nxt;
    logic            w_carry;
    logic [SW-1:0]   r_bcd;
    logic            r_ovf_s;
    logic            r_ovf;
`ifdef BIN2BCD_SIGNED_EN
    logic            r_neg;
    logic            r_sign;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_last   = 1'b0;
        unique case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_next   = SHIFT;
                    w_accept = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            SHIFT: begin
                if (r_cnt == CW'(1)) begin
                    w_next = DONE;
                    w_last = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Add-3 correction on every digit that would exceed 9 after doubling.
    always_comb begin
        w_adj = r_scr;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_scr[4*d +: 4] >= 4'd5)
                w_adj[4*d +: 4] = r_scr[4*d +: 4] + 4'd3;
        end
        w_carry   = w_adj[SW-1];
        w_scr_nxt = {w_adj[SW-2:0], r_op[BIN_W-1]};
    end

`ifdef BIN2BCD_SIGNED_EN
    // -2^(BIN_W-1) negates to itself, which reads correctly as unsigned.
    assign w_mag = bin[BIN_W-1] ? BIN_W'(-bin) : bin;
`else
    assign w_mag = bin;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_op    <= '0;
            r_scr   <= '0;
            r_ovf_s <= 1'b0;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
            r_neg   <= 1'b0;
            r_sign  <= 1'b0;
`endif
        end else if (w_accept) begin
            r_cnt   <= CW'(BIN_W);
            r_op    <= w_mag;
            r_scr   <= '0;
            r_ovf_s <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
            r_neg   <= bin[BIN_W-1];
`endif
        end else if (r_state == SHIFT) begin
            r_cnt   <= r_cnt - CW'(1);
            r_op    <= r_op << 1;
            r_scr   <= w_scr_nxt;
            r_ovf_s <= r_ovf_s | w_carry;
            if (w_last) begin
                r_bcd  <= w_scr_nxt;
                r_ovf  <= r_ovf_s | w_carry;
`ifdef BIN2BCD_SIGNED_EN
                r_sign <= r_neg;
`endif
            end
        end
    end

    assign busy = (r_state == SHIFT);
    assign done = (r_state == DONE);
    assign bcd  = r_bcd;
    assign ovf  = r_ovf;
`ifdef BIN2BCD_SIGNED_EN
    assign sign = r_sign;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: three instances (8b/3 digits, 8b/2 digits, 16b/5 digits)
// checked against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0;
    logic [7:0]  bin_a = '0;
    logic        start_c = 1'b0;
    logic [15:0] bin_c = '0;

    logic        busy_a, done_a, ovf_a;
    logic [11:0] bcd_a;
    logic        busy_b, done_b, ovf_b;
    logic [7:0]  bcd_b;
    logic        busy_c, done_c, ovf_c;
    logic [19:0] bcd_c;
`ifdef BIN2BCD_SIGNED_EN
    logic        sign_a, sign_b, sign_c;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [39:0] bcd;
        logic        ovf;
        logic        sgn;
        int          acc;
        int          dn;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    logic [40:0] last_a = '0;
    logic [40:0] last_b = '0;
    logic [40:0] last_c = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .bin(bin_a),
        .busy(busy_a), .done(done_a), .bcd(bcd_a), .ovf(ovf_a)
`ifdef BIN2BCD_SIGNED_EN
        , .sign(sign_a)
`endif
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_b (
        .clk(clk), .rst(rst), .start(start_a), .bin(bin_a),
        .busy(busy_b), .done(done_b), .bcd(bcd_b), .ovf(ovf_b)
`ifdef BIN2BCD_SIGNED_EN
        , .sign(sign_b)
`endif
    );

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .bin(bin_c),
        .busy(busy_c), .done(done_c), .bcd(bcd_c), .ovf(ovf_c)
`ifdef BIN2BCD_SIGNED_EN
        , .sign(sign_c)
`endif
    );

    // Reference: decimal digits of the magnitude by division, overflow by range.
    function automatic exp_t model(input logic [31:0] v, input int w,
                                   input int nd, input int acc);
        exp_t e;
        longint unsigned mag;
        longint unsigned p;
        mag   = v & ((64'd1 << w) - 1);
        e.sgn = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
        if (v[w-1]) begin
            e.sgn = 1'b1;
            mag   = (64'd1 << w) - mag;
        end
`endif
        e.bcd = '0;
        p     = 1;
        for (int d = 0; d < nd; d++) begin
            e.bcd[4*d +: 4] = 4'((mag / p) % 10);
            p = p * 10;
        end
        e.ovf = (mag >= p);
        e.acc = acc;
        e.dn  = acc + w;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [40:0] got,
                       input logic [40:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", nm, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("a_busy", busy_a, (qa.size() > 0 && cyc >= qa[0].acc && cyc < qa[0].dn));
            if (done_a) begin
                if (qa.size() == 0) begin
                    chk("a_extra_done", done_a, 1'b0);
                end else begin
                    e = qa.pop_front();
                    chk("a_lat", cyc, e.dn);
                    chk("a_res", {ovf_a, bcd_a}, {e.ovf, e.bcd[11:0]});
`ifdef BIN2BCD_SIGNED_EN
                    chk("a_sign", sign_a, e.sgn);
`endif
                    last_a = {e.ovf, e.bcd[11:0]};
                end
            end else begin
                chk("a_hold", {ovf_a, bcd_a}, last_a);
                if (qa.size() > 0 && cyc == qa[0].dn) begin
                    chk("a_done", done_a, 1'b1);
                    void'(qa.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("b_busy", busy_b, (qb.size() > 0 && cyc >= qb[0].acc && cyc < qb[0].dn));
            if (done_b) begin
                if (qb.size() == 0) begin
                    chk("b_extra_done", done_b, 1'b0);
                end else begin
                    e = qb.pop_front();
                    chk("b_lat", cyc, e.dn);
                    chk("b_res", {ovf_b, bcd_b}, {e.ovf, e.bcd[7:0]});
`ifdef BIN2BCD_SIGNED_EN
                    chk("b_sign", sign_b, e.sgn);
`endif
                    last_b = {e.ovf, e.bcd[7:0]};
                end
            end else begin
                chk("b_hold", {ovf_b, bcd_b}, last_b);
                if (qb.size() > 0 && cyc == qb[0].dn) begin
                    chk("b_done", done_b, 1'b1);
                    void'(qb.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("c_busy", busy_c, (qc.size() > 0 && cyc >= qc[0].acc && cyc < qc[0].dn));
            if (done_c) begin
                if (qc.size() == 0) begin
                    chk("c_extra_done", done_c, 1'b0);
                end else begin
                    e = qc.pop_front();
                    chk("c_lat", cyc, e.dn);
                    chk("c_res", {ovf_c, bcd_c}, {e.ovf, e.bcd[19:0]});
`ifdef BIN2BCD_SIGNED_EN
                    chk("c_sign", sign_c, e.sgn);
`endif
                    last_c = {e.ovf, e.bcd[19:0]};
                end
            end else begin
                chk("c_hold", {ovf_c, bcd_c}, last_c);
                if (qc.size() > 0 && cyc == qc[0].dn) begin
                    chk("c_done", done_c, 1'b1);
                    void'(qc.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Drives start for one edge; the next edge (cyc+1) accepts it.
    task automatic issue_a(input logic [7:0] v);
        start_a = 1'b1;
        bin_a   = v;
        qa.push_back(model(32'(v), 8, 3, cyc + 1));
        qb.push_back(model(32'(v), 8, 2, cyc + 1));
        tick();
        start_a = 1'b0;
    endtask

    // Returns inside the DONE cycle so a following call is back-to-back.
    task automatic conv_a(input logic [7:0] v);
        issue_a(v);
        repeat (8) tick();
    endtask

    task automatic conv_c(input logic [15:0] v);
        start_c = 1'b1;
        bin_c   = v;
        qc.push_back(model(32'(v), 16, 5, cyc + 1));
        tick();
        start_c = 1'b0;
        repeat (16) tick();
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        conv_a(8'd255);
        tick();
        conv_a(8'd0);
        conv_a(8'd100);
        tick();
        conv_a(8'd99);
        tick();
        conv_a(8'h80);
        conv_a(8'hFF);
        conv_a(8'd9);
        conv_a(8'd10);
        tick();

        // start while busy must be ignored
        issue_a(8'd42);
        repeat (2) tick();
        start_a = 1'b1;
        bin_a   = 8'd7;
        tick();
        start_a = 1'b0;
        bin_a   = 8'd0;
        repeat (5) tick();
        repeat (2) tick();

        // reset mid-conversion aborts without a done pulse
        issue_a(8'd200);
        repeat (3) tick();
        rst = 1'b1;
        qa.delete();
        qb.delete();
        last_a = '0;
        last_b = '0;
        tick();
        rst = 1'b0;
        repeat (12) tick();

        for (int i = 0; i < 40; i++) begin
            conv_a(8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 2)) tick();
        end

        conv_c(16'd65535);
        conv_c(16'd0);
        conv_c(16'd10000);
        tick();
        for (int i = 0; i < 10; i++) begin
            conv_c(16'($urandom_range(0, 65535)));
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (20) tick();
        chk("a_pending", qa.size(), 0);
        chk("b_pending", qb.size(), 0);
        chk("c_pending", qc.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
